polylut_argmax_out: RTL and testbench
=====================================

Name: polylut_argmax_out

Overview:
- Output stage directly downstream of the polylut_add core. Consumes the packed per-class scores on M10.
- Uses a valid bit delayed to match the core's fixed register latency. Computes the winning class with a 2-stage pipelined signed argmax.
- Buffers results in a small FIFO with valid/ready handshake toward the host/DMA side.
- The core cannot stall, so results arriving at a full FIFO are dropped and counted.

Parameters:
- NUM_CLASSES, 5, number of class scores packed in M10
- OUT_BITS, 5, width of each class score (two's complement)
- CORE_LATENCY, 5, clock edges from M0/in_valid sampled by the core to matching M10
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
- CNT_BITS, 16, width of drop counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  qualifies M0 presented to the core in the same cycle
- M10  input  NUM_CLASSES*OUT_BITS  core output; class k occupies bits [k*OUT_BITS +: OUT_BITS]
- out_valid  output  1  FIFO head holds a result
- out_ready  input  1  consumer accepts head when out_valid&out_ready
- out_class  output  3  winning class index (clog2(NUM_CLASSES))
- out_score  output  OUT_BITS  winning score
- overflow  output  1  sticky: at least one result dropped
- drop_count  output  CNT_BITS  number of dropped results, saturating

Behaviour:
- Reset (synchronous, clk edge with rst=1) clears:
  - the valid delay line, stage A/B valids and FIFO pointers/count;
  - overflow and drop_count;
  - out_valid=0, out_class=0, out_score=0.
- Reset mid-operation discards all in-flight and buffered results. The core data path is not touched.
- Valid alignment:
  - in_valid enters a CORE_LATENCY-deep shift register.
  - The tap v_al is high in exactly the cycle in which the matching M10 is present.
  - in_valid at cycle t gives v_al at cycle t+CORE_LATENCY.
- Stage A, registered, loads every cycle:
  - compare pairs (c0,c1) and (c2,c3); c4 passes through;
  - store winner index and score per pair, plus vA=v_al.
- Stage B, registered:
  - compare pair winners, then the result against c4;
  - store class, score and vB=vA.
- Comparison rules:
  - signed two's-complement compare at OUT_BITS width;
  - a candidate replaces the current best only if strictly greater, so ties go to the lowest index.
- FIFO push:
  - vB=1 pushes {class,score} on the next edge.
  - Latency: M10 valid at cycle n gives out_valid at n+3 when the FIFO was empty. There is no bypass.
- FIFO pop:
  - out_valid&out_ready pops at the edge.
  - out_class/out_score show the head while out_valid=1 and are driven 0 while empty.
- Full FIFO:
  - Push while full with no pop drops the new result (FIFO contents unchanged).
  - The same edge sets overflow=1 and increments drop_count, saturating at all-ones.
  - Push while full with a simultaneous pop is accepted: count unchanged, no drop.
- Empty FIFO: pop with no entry does not occur (out_valid=0), and out_ready is ignored.
- Pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses an explicit occupancy count.
- out_valid is a registered function of occupancy. Once high it stays high with a stable head until popped.
- overflow stays set until rst.

Test Plan:
- Reset check: hold rst 3 cycles with in_valid=1 and random M10, then release -> out_valid=0, overflow=0, drop_count=0. No output until 5+3 cycles after the first post-reset in_valid.
- Basic argmax: in_valid pulse at t with M10 fields c0=3, c1=-2, c2=6, c3=1, c4=-16 -> out_valid at t+8, out_class=2, out_score=6. Pop with out_ready=1, then out_valid=0 the next cycle.
- Ties and negative scores:
  - all fields=7 -> class 0, score 7;
  - c0=-16, c1=-16, c2=-3, c3=-3, c4=-3 -> class 2, score -3;
  - c4=15 with others 14 -> class 4.
- Back-to-back streaming: in_valid=1 for 20 cycles with distinct vectors and out_ready=1 -> 20 results in order, each 8 cycles after its input, no gaps, overflow=0.
- Backpressure/overflow: out_ready=0, 6 consecutive valid inputs with FIFO_DEPTH=4 -> first 4 held, overflow=1, drop_count=2. Then out_ready=1 -> exactly those 4 drain in order.
- Full with simultaneous push/pop: fill to 4, then out_ready=1 for one cycle while a push arrives -> occupancy stays 4, no drop, new result at the tail. Also assert rst while the FIFO holds 3 entries -> all cleared next cycle.

Source files
------------

// File: rtl/polylut_argmax_out.sv
// Output stage for the polylut_add core: aligns the core's valid, picks the winning class
// with a two-stage signed argmax, and queues results for the host behind a dropping FIFO.
module polylut_argmax_out #(
    parameter int unsigned NUM_CLASSES  = 5,
    parameter int unsigned OUT_BITS     = 5,
    parameter int unsigned CORE_LATENCY = 5,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_BITS     = 16,
    localparam int unsigned CLS_BITS    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [NUM_CLASSES*OUT_BITS-1:0] M10,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CLS_BITS-1:0]             out_class,
    output logic [OUT_BITS-1:0]             out_score,
    output logic                            overflow,
    output logic [CNT_BITS-1:0]             drop_count
);

    localparam int unsigned NUM_A    = (NUM_CLASSES + 1) / 2;
    localparam int unsigned PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_BITS = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_BITS = CLS_BITS + OUT_BITS;

    // Valid alignment: the tap is high in the cycle the matching M10 is present.
    logic [CORE_LATENCY-1:0] r_vdly;
    logic                    w_v_al;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vdly <= '0;
        end else begin
            r_vdly <= (r_vdly << 1) | CORE_LATENCY'(in_valid);
        end
    end

    assign w_v_al = r_vdly[CORE_LATENCY-1];

    logic signed [OUT_BITS-1:0] w_c [NUM_CLASSES];

    always_comb begin
        for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            w_c[k] = M10[k*OUT_BITS +: OUT_BITS];
        end
    end

    // Stage A: pairwise compare; an unpaired last class compares against itself and passes.
    logic [CLS_BITS-1:0]        w_a_idx   [NUM_A];
    logic signed [OUT_BITS-1:0] w_a_score [NUM_A];
    logic [CLS_BITS-1:0]        r_a_idx   [NUM_A];
    logic signed [OUT_BITS-1:0] r_a_score [NUM_A];
    logic                       r_va;

    always_comb begin
        for (int i = 0; i < int'(NUM_A); i++) begin
            int j;
            j = (2 * i + 1 < int'(NUM_CLASSES)) ? 2 * i + 1 : 2 * i;
            w_a_idx[i]   = CLS_BITS'(2 * i);
            w_a_score[i] = w_c[2*i];
            if (w_c[j] > w_c[2*i]) begin
                w_a_idx[i]   = CLS_BITS'(j);
                w_a_score[i] = w_c[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_va <= 1'b0;
        end else begin
            r_va <= w_v_al;
        end
    end

    always_ff @(posedge clk) begin
        r_a_idx   <= w_a_idx;
        r_a_score <= w_a_score;
    end

    // Stage B: reduce in index order with strict greater-than so ties keep the lower index.
    logic [CLS_BITS-1:0]        w_b_idx;
    logic signed [OUT_BITS-1:0] w_b_score;
    logic [CLS_BITS-1:0]        r_b_idx;
    logic signed [OUT_BITS-1:0] r_b_score;
    logic                       r_vb;

    always_comb begin
        w_b_idx   = r_a_idx[0];
        w_b_score = r_a_score[0];
        for (int i = 1; i < int'(NUM_A); i++) begin
            if (r_a_score[i] > w_b_score) begin
                w_b_idx   = r_a_idx[i];
                w_b_score = r_a_score[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vb <= 1'b0;
        end else begin
            r_vb <= r_va;
        end
    end

    always_ff @(posedge clk) begin
        r_b_idx   <= w_b_idx;
        r_b_score <= w_b_score;
    end

    // Result FIFO; the core cannot stall, so a push into a full FIFO without a pop is dropped.
    logic [ENT_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [OCC_BITS-1:0] r_occ;
    logic [OCC_BITS-1:0] w_occ_d;
    logic                r_out_valid;
    logic                r_overflow;
    logic [CNT_BITS-1:0] r_drop_cnt;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [ENT_BITS-1:0] w_head;

    assign w_full = (r_occ == OCC_BITS'(FIFO_DEPTH));
    assign w_pop  = r_out_valid & out_ready;
    assign w_push = r_vb & (~w_full | w_pop);
    assign w_drop = r_vb & w_full & ~w_pop;

    always_comb begin
        w_occ_d = r_occ;
        if (w_push && !w_pop) begin
            w_occ_d = r_occ + 1'b1;
        end else if (!w_push && w_pop) begin
            w_occ_d = r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ       <= w_occ_d;
            r_out_valid <= (w_occ_d != '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_b_idx, r_b_score};
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = r_out_valid;
    assign out_class  = r_out_valid ? w_head[ENT_BITS-1 -: CLS_BITS] : '0;
    assign out_score  = r_out_valid ? w_head[OUT_BITS-1:0] : '0;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_polylut_argmax_out.sv
// Directed bench for polylut_argmax_out; a small delay line stands in for the core so M10
// arrives CORE_LATENCY cycles after the in_valid that qualifies it.
module tb_polylut_argmax_out;

    localparam int NC    = 5;
    localparam int OB    = 5;
    localparam int LAT   = 5;
    localparam int DEPTH = 4;
    localparam int CB    = 16;
    localparam int W     = NC * OB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  m0;
    logic [W-1:0]  m10;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_class;
    logic [OB-1:0] out_score;
    logic          overflow;
    logic [CB-1:0] drop_count;

    logic [W-1:0]  core_pipe [LAT];
    logic [W-1:0]  vecs [20];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        core_pipe[0] <= m0;
    end

    assign m10 = core_pipe[LAT-1];

    polylut_argmax_out #(
        .NUM_CLASSES (NC),
        .OUT_BITS    (OB),
        .CORE_LATENCY(LAT),
        .FIFO_DEPTH  (DEPTH),
        .CNT_BITS    (CB)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .M10       (m10),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] pk(input int c0, input int c1, input int c2, input int c3,
                                        input int c4);
        return {5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    // Reference argmax over the packed word: {class, score}.
    function automatic logic [7:0] ref_max(input logic [W-1:0] v);
        logic signed [OB-1:0] best;
        logic signed [OB-1:0] s;
        logic [2:0]           bi;
        best = v[OB-1:0];
        bi   = 3'd0;
        for (int k = 1; k < NC; k++) begin
            s = v[k*OB +: OB];
            if (s > best) begin
                best = s;
                bi   = 3'(k);
            end
        end
        return {bi, best};
    endfunction

    task automatic check_head(input string tag, input logic [7:0] exp);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_class"}, 32'(out_class), 32'(exp[7:5]));
        check_eq({tag, "_score"}, 32'(out_score), 32'(exp[4:0]));
    endtask

    task automatic send(input logic [W-1:0] v);
        in_valid = 1'b1;
        m0       = v;
        tick();
        in_valid = 1'b0;
        m0       = '0;
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] v, input logic [2:0] cls,
                           input logic [4:0] score);
        send(v);
        repeat (6) tick();
        check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check_head(tag, {cls, score});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_popped"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        m0        = '0;

        // Reset with in_valid held high and random core data.
        repeat (3) begin
            m0 = W'($urandom);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        m0       = '0;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_drops", 32'(drop_count), 32'd0);
        check_eq("rst_class", 32'(out_class), 32'd0);
        check_eq("rst_score", 32'(out_score), 32'd0);
        repeat (10) tick();
        check_eq("rst_quiet", 32'(out_valid), 32'd0);

        run_one("basic", pk(3, -2, 6, 1, -16), 3'd2, 5'd6);
        run_one("tie_all7", pk(7, 7, 7, 7, 7), 3'd0, 5'd7);
        run_one("tie_neg", pk(-16, -16, -3, -3, -3), 3'd2, 5'h1D);
        run_one("c4_wins", pk(14, 14, 14, 14, 15), 3'd4, 5'd15);

        // Back-to-back streaming with the consumer always ready.
        for (int i = 0; i < 20; i++) begin
            vecs[i] = pk((i * 7 + 3) % 32 - 16, (i * 11 + 5) % 32 - 16, (i * 13 + 9) % 32 - 16,
                         (i * 3 + 1) % 32 - 16, (i * 5 + 14) % 32 - 16);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 29; cyc++) begin
            logic exp_v;
            if (cyc < 20) begin
                in_valid = 1'b1;
                m0       = vecs[cyc];
            end else begin
                in_valid = 1'b0;
                m0       = '0;
            end
            exp_v = (cyc >= 8) && (cyc < 28);
            check_eq("stream_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) begin
                check_eq("stream_class", 32'(out_class), 32'(ref_max(vecs[cyc-8]) >> 5));
                check_eq("stream_score", 32'(out_score), 32'(ref_max(vecs[cyc-8]) & 8'h1F));
            end
            tick();
        end
        out_ready = 1'b0;
        check_eq("stream_overflow", 32'(overflow), 32'd0);

        // Six results into a four-entry FIFO with no consumer: the last two are dropped.
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] v;
            v = pk(-10, -10, -10, -10, -10);
            v[(k % 5)*OB +: OB] = 5'(k + 1);
            in_valid = 1'b1;
            m0       = v;
            tick();
        end
        in_valid = 1'b0;
        m0       = '0;
        repeat (10) tick();
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_drops", 32'(drop_count), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head("ovf_drain", {3'(k % 5), 5'(k + 1)});
            tick();
        end
        check_eq("ovf_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Fill to four, then pop on the same edge a fifth result arrives.
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 5) begin
                logic [W-1:0] v;
                v = pk(-16, -16, -16, -16, -16);
                v[cyc*OB +: OB] = 5'(2 * cyc + 1);
                in_valid = 1'b1;
                m0       = v;
            end else begin
                in_valid = 1'b0;
                m0       = '0;
            end
            if (cyc == 11) begin
                check_head("full_head0", {3'd0, 5'd1});
                out_ready = 1'b1;
            end
            tick();
        end
        out_ready = 1'b0;
        check_eq("full_nodrop", 32'(drop_count), 32'd2);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check_head("full_drain", {3'(k), 5'(2 * k + 1)});
            tick();
        end
        check_eq("full_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset with three buffered results and one still in flight.
        for (int k = 0; k < 3; k++) send(pk(k, 9, -1, -1, -1));
        repeat (9) tick();
        check_head("rst3_head", {3'd1, 5'd9});
        send(pk(12, 0, 0, 0, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst3_valid", 32'(out_valid), 32'd0);
        check_eq("rst3_overflow", 32'(overflow), 32'd0);
        check_eq("rst3_drops", 32'(drop_count), 32'd0);
        check_eq("rst3_class", 32'(out_class), 32'd0);
        check_eq("rst3_score", 32'(out_score), 32'd0);
        repeat (12) tick();
        check_eq("rst3_inflight", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
